i2c_slave: RTL and testbench

I2C target (responder) for the two-wire bus driven by the team's `master` block. It oversamples `sclk`/`sda_in` on the system clock, detects START/STOP, matches a 7-bit address and ACKs it, then receives write bytes or transmits read bytes. Multi-byte transfers and repeated START are supported. It sits opposite `master` on the split-SDA interface (`sda_in`/`sda_out`) and hands bytes to and from local logic through a one-cycle pulse handshake.

---
 rtl/i2c_slave_if.sv | 22 ++
 rtl/i2c_slave.sv | 191 +++++++++++++++++++
 tb/tb_i2c_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_if.sv
// Split-SDA I2C bus plus the local byte handshake between the target and its user logic.
interface i2c_slave_if;
  logic       sclk;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_req;
  logic       rw;
  logic [2:0] state;

  modport slave (
    input  sclk, sda_in, data_in,
    output sda_out, data_out, data_valid, data_req, rw, state
  );

  modport master (
    output sclk, sda_in, data_in,
    input  sda_out, data_out, data_valid, data_req, rw, state
  );
endinterface

// File: rtl/i2c_slave.sv
// I2C target: oversamples SCL/SDA, detects START/STOP, ACKs its 7-bit address and
// receives write bytes or transmits read bytes through a one-cycle pulse handshake.
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h2A
) (
  input  logic          clk,
  input  logic          rst,
  i2c_slave_if.slave    bus
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned SYNC_W = 3;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDRESS   = 3'd1,
    ADDR_ACK  = 3'd2,
    RECEIVE   = 3'd3,
    RECV_ACK  = 3'd4,
    TRANSMIT  = 3'd5,
    TX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_W-1:0]   scl_sync_q, scl_sync_d;
  logic [SYNC_W-1:0]   sda_sync_q, sda_sync_d;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;
  logic                sda_out_q, sda_out_d;
  logic                data_valid_q, data_valid_d;
  logic                data_req_q, data_req_d;
  logic                rw_q, rw_d;

  logic scl_s, sda_s;
  logic scl_rise_c, scl_fall_c, sda_rise_c, sda_fall_c;
  logic start_c, stop_c;

  // Bit 1 is the synchronized level; bit 2 is the delayed copy for edge detection.
  assign scl_sync_d = {scl_sync_q[1:0], bus.sclk};
  assign sda_sync_d = {sda_sync_q[1:0], bus.sda_in};
  assign scl_s      = scl_sync_q[1];
  assign sda_s      = sda_sync_q[1];
  assign scl_rise_c =  scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall_c = ~scl_sync_q[1] &  scl_sync_q[2];
  assign sda_rise_c =  sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_fall_c = ~sda_sync_q[1] &  sda_sync_q[2];
  assign start_c    = sda_fall_c & scl_s;
  assign stop_c     = sda_rise_c & scl_s;

  // Next-state and output logic; ACK phases use sda_out_q to tell drive-low from release.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    sda_out_d    = sda_out_q;
    rw_d         = rw_q;
    data_valid_d = 1'b0;
    data_req_d   = 1'b0;

    if (start_c) begin
      state_d   = ADDRESS;
      bit_cnt_d = '0;
      sda_out_d = 1'b1;
    end else if (stop_c) begin
      state_d   = IDLE;
      sda_out_d = 1'b1;
    end else begin
      case (state_q)
        IDLE, WAIT_STOP: sda_out_d = 1'b1;

        ADDRESS: if (scl_rise_c) begin
          shift_d   = {shift_q[DATA_W-2:0], sda_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            if (shift_q[6:0] == ADDR) begin
              rw_d    = sda_s;
              state_d = ADDR_ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end

        ADDR_ACK: if (scl_fall_c) begin
          if (sda_out_q) begin
            sda_out_d = 1'b0;
          end else if (rw_q) begin
            data_req_d = 1'b1;
            shift_d    = bus.data_in;
            sda_out_d  = bus.data_in[DATA_W-1];
            bit_cnt_d  = '0;
            state_d    = TRANSMIT;
          end else begin
            sda_out_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = RECEIVE;
          end
        end

        RECEIVE: if (scl_rise_c) begin
          shift_d   = {shift_q[DATA_W-2:0], sda_s};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            data_out_d   = {shift_q[DATA_W-2:0], sda_s};
            data_valid_d = 1'b1;
            state_d      = RECV_ACK;
          end
        end

        RECV_ACK: if (scl_fall_c) begin
          if (sda_out_q) begin
            sda_out_d = 1'b0;
          end else begin
            sda_out_d = 1'b1;
            bit_cnt_d = '0;
            state_d   = RECEIVE;
          end
        end

        // MSB is already on the bus at entry; each fall presents the next bit.
        TRANSMIT: if (scl_fall_c) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(7)) begin
            sda_out_d = 1'b1;
            state_d   = TX_ACK;
          end else begin
            sda_out_d = shift_q[DATA_W-2];
            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
          end
        end

        // A NACK leaves on the rise, so any fall seen here follows an ACK.
        TX_ACK: begin
          if (scl_rise_c && sda_s) begin
            state_d = WAIT_STOP;
          end else if (scl_fall_c) begin
            data_req_d = 1'b1;
            shift_d    = bus.data_in;
            sda_out_d  = bus.data_in[DATA_W-1];
            bit_cnt_d  = '0;
            state_d    = TRANSMIT;
          end
        end

        default: begin
          state_d   = IDLE;
          sda_out_d = 1'b1;
        end
      endcase
    end
  end

  // Sync chains reset to the idle-bus level so reset release creates no edges.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      sda_out_q    <= 1'b1;
      data_valid_q <= 1'b0;
      data_req_q   <= 1'b0;
      rw_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      sda_out_q    <= sda_out_d;
      data_valid_q <= data_valid_d;
      data_req_q   <= data_req_d;
      rw_q         <= rw_d;
    end
  end

  assign bus.sda_out    = sda_out_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.data_req   = data_req_q;
  assign bus.rw         = rw_q;
  assign bus.state      = 3'(state_q);

endmodule

// File: tb/tb_i2c_slave.sv
// Directed bench for i2c_slave: a bit-banged bus master with a wired-AND SDA line
// and hand-computed expectations for ACKs, bytes and handshake pulse counts.
module tb_i2c_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        scl = 1'b1;
  logic        m_sda = 1'b1;
  logic [31:0] dreq_cnt = 0;
  logic [31:0] dv_cnt = 0;
  logic [31:0] overlap_cnt = 0;
  logic [31:0] wide_cnt = 0;
  logic        dv_prev = 1'b0;
  logic        dreq_prev = 1'b0;
  logic [7:0]  rd_vals [0:15];
  int          n_cmp = 0;
  int          n_err = 0;

  i2c_slave_if bus ();

  assign bus.sclk    = scl;
  assign bus.sda_in  = m_sda & bus.sda_out;
  assign bus.data_in = rd_vals[dreq_cnt[3:0]];

  i2c_slave #(.ADDR(7'h2A)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Handshake monitor: pulse counts, overlap and width violations; read data advances after each request.
  always @(posedge clk) begin
    if (bus.data_valid) dv_cnt <= dv_cnt + 1;
    if (bus.data_req)   dreq_cnt <= dreq_cnt + 1;
    if (bus.data_valid && bus.data_req) overlap_cnt <= overlap_cnt + 1;
    if ((bus.data_valid && dv_prev) || (bus.data_req && dreq_prev)) wide_cnt <= wide_cnt + 1;
    dv_prev   <= bus.data_valid;
    dreq_prev <= bus.data_req;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic settle();
    wclk(6);
    @(negedge clk);
  endtask

  // One SCL period starting with SCL low: master drives mb, line level sampled mid-high.
  task automatic clk_bit(input logic mb, output logic line);
    wclk(2);
    m_sda = mb;
    wclk(6);
    scl = 1'b1;
    wclk(4);
    @(negedge clk);
    line = bus.sda_in;
    wclk(4);
    scl = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] mout, input logic m9,
                      output logic [7:0] line8, output logic line9);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(mout[i], b);
      line8[i] = b;
    end
    clk_bit(m9, line9);
  endtask

  // Works from idle (SCL high) and as a repeated START (SCL low).
  task automatic bus_start();
    if (!scl) begin
      wclk(2);
      m_sda = 1'b1;
      wclk(6);
      scl = 1'b1;
      wclk(6);
    end
    m_sda = 1'b0;
    wclk(8);
    scl = 1'b0;
  endtask

  task automatic bus_stop();
    wclk(2);
    m_sda = 1'b0;
    wclk(6);
    scl = 1'b1;
    wclk(6);
    m_sda = 1'b1;
    wclk(8);
  endtask

  logic [7:0] l8;
  logic       l9;
  logic       b;

  initial begin
    rd_vals[0] = 8'hF6;
    rd_vals[1] = 8'h3C;
    rd_vals[2] = 8'hC3;
    rd_vals[3] = 8'h5A;
    for (int i = 4; i < 16; i++) rd_vals[i] = 8'h00;

    // Reset values
    wclk(4);
    @(negedge clk);
    check("rst_sda_out",  32'(bus.sda_out),    32'h1);
    check("rst_data_out", 32'(bus.data_out),   32'h00);
    check("rst_dvalid",   32'(bus.data_valid), 32'h0);
    check("rst_dreq",     32'(bus.data_req),   32'h0);
    check("rst_rw",       32'(bus.rw),         32'h0);
    check("rst_state",    32'(bus.state),      32'h0);
    rst = 1'b1;
    wclk(4);

    // Write 0x2A/W, 0xA5
    bus_start();
    xfer(8'h54, 1'b1, l8, l9);
    check("wr_addr_ack", 32'(l9), 32'h0);
    settle();
    check("wr_state_recv", 32'(bus.state), 32'h3);
    check("wr_rw", 32'(bus.rw), 32'h0);
    xfer(8'hA5, 1'b1, l8, l9);
    check("wr_data_ack", 32'(l9), 32'h0);
    check("wr_data_out", 32'(bus.data_out), 32'hA5);
    check("wr_dv_cnt", dv_cnt, 32'd1);
    bus_stop();
    settle();
    check("wr_state_idle", 32'(bus.state), 32'h0);

    // Read 0x2A/R, 0xF6, master NACK
    bus_start();
    xfer(8'h55, 1'b1, l8, l9);
    check("rd_addr_ack", 32'(l9), 32'h0);
    settle();
    check("rd_rw", 32'(bus.rw), 32'h1);
    check("rd_state_tx", 32'(bus.state), 32'h5);
    xfer(8'hFF, 1'b1, l8, l9);
    check("rd_byte", 32'(l8), 32'hF6);
    check("rd_dreq_cnt", dreq_cnt, 32'd1);
    settle();
    check("rd_state_wait", 32'(bus.state), 32'h7);
    bus_stop();
    settle();
    check("rd_state_idle", 32'(bus.state), 32'h0);

    // Two-byte read 0x3C, 0xC3
    bus_start();
    xfer(8'h55, 1'b1, l8, l9);
    check("rd2_addr_ack", 32'(l9), 32'h0);
    xfer(8'hFF, 1'b0, l8, l9);
    check("rd2_byte0", 32'(l8), 32'h3C);
    xfer(8'hFF, 1'b1, l8, l9);
    check("rd2_byte1", 32'(l8), 32'hC3);
    check("rd2_dreq_cnt", dreq_cnt, 32'd3);
    bus_stop();

    // Wrong address 0x2B/W
    bus_start();
    xfer(8'h56, 1'b1, l8, l9);
    check("na_ack_slot", 32'(l9), 32'h1);
    settle();
    check("na_state_wait", 32'(bus.state), 32'h7);
    xfer(8'h00, 1'b1, l8, l9);
    check("na_data_ack", 32'(l9), 32'h1);
    check("na_dv_cnt", dv_cnt, 32'd1);
    bus_stop();

    // Repeated START after 4 data bits, then read 0x5A
    bus_start();
    xfer(8'h54, 1'b1, l8, l9);
    check("rs_addr_ack", 32'(l9), 32'h0);
    clk_bit(1'b1, b);
    clk_bit(1'b0, b);
    clk_bit(1'b1, b);
    clk_bit(1'b0, b);
    bus_start();
    settle();
    check("rs_state_addr", 32'(bus.state), 32'h1);
    xfer(8'h55, 1'b1, l8, l9);
    check("rs_rd_ack", 32'(l9), 32'h0);
    xfer(8'hFF, 1'b1, l8, l9);
    check("rs_rd_byte", 32'(l8), 32'h5A);
    check("rs_dv_cnt", dv_cnt, 32'd1);
    bus_stop();

    // Reset during RECEIVE bit 5, then write 0x11
    bus_start();
    xfer(8'h54, 1'b1, l8, l9);
    check("mr_addr_ack", 32'(l9), 32'h0);
    for (int i = 0; i < 4; i++) clk_bit(1'b0, b);
    wclk(2);
    m_sda = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mr_sda_out", 32'(bus.sda_out), 32'h1);
    check("mr_state", 32'(bus.state), 32'h0);
    scl = 1'b1;
    wclk(4);
    @(negedge clk);
    rst = 1'b1;
    settle();
    check("mr_state_after", 32'(bus.state), 32'h0);
    bus_start();
    xfer(8'h54, 1'b1, l8, l9);
    check("mr2_addr_ack", 32'(l9), 32'h0);
    xfer(8'h11, 1'b1, l8, l9);
    check("mr2_data_ack", 32'(l9), 32'h0);
    check("mr2_data_out", 32'(bus.data_out), 32'h11);
    check("mr2_dv_cnt", dv_cnt, 32'd2);
    bus_stop();
    settle();
    check("mr2_state_idle", 32'(bus.state), 32'h0);

    check("pulse_overlap", overlap_cnt, 32'd0);
    check("pulse_width", wide_cnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
